// File: rtl/wb_stage.sv
// wb_stage: MEM/WB pipeline register and write-back selector.
// Drives the write port of the 16-entry register file, which commits on the
// falling edge after each capture. Keeps committed/dropped write counters.
// Optional feature macro: WB_PC_WRITE_EN (allows writes to R15 and drives
// pc_load); when undefined, R15 writes are suppressed and counted as drops.
module wb_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              flush,
  input  logic              mem_valid,
  input  logic              wb_en_in,
  input  logic              mem_r_en_in,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] mem_result,
  input  logic [3:0]        dest_in,
  output logic [3:0]        Dest_wb,
  output logic [DATA_W-1:0] Result_WB,
  output logic              writeBackEn,
  output logic              pc_load,
  output logic [CNT_W-1:0]  wb_count,
  output logic [CNT_W-1:0]  drop_count
);

  localparam logic [3:0]       PcIdx   = 4'd15;
  localparam logic [CNT_W-1:0] CntOne  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CntZero = '0;

  logic [3:0]        dest_q;
  logic [DATA_W-1:0] result_q;
  logic              we_q;
  logic [CNT_W-1:0]  wb_count_q;
  logic [CNT_W-1:0]  drop_count_q;

  logic              wr;
  logic              to_pc;
  logic [DATA_W-1:0] result_d;
  logic              we_d;
  logic              drop_d;
  logic [CNT_W-1:0]  wb_count_d;
  logic [CNT_W-1:0]  drop_count_d;

`ifdef WB_PC_WRITE_EN
  logic pc_q;
  logic pc_d;
`endif

  // Next-state values for a plain load cycle (no rst/flush/freeze).
  always_comb begin
    wr       = mem_valid & wb_en_in;
    to_pc    = (dest_in == PcIdx);
    // Write-back mux sits ahead of the register so outputs are purely registered.
    result_d = mem_r_en_in ? mem_result : alu_result;
`ifdef WB_PC_WRITE_EN
    we_d     = wr;
    pc_d     = wr & to_pc;
    drop_d   = 1'b0;
`else
    // R15 is reserved: a real write to it is suppressed and counted.
    we_d     = wr & ~to_pc;
    drop_d   = wr & to_pc;
`endif
    wb_count_d   = wb_count_q + (we_d ? CntOne : CntZero);
    drop_count_d = drop_count_q + (drop_d ? CntOne : CntZero);
  end

  // Pipeline register: rst > flush > freeze > load.
  always_ff @(posedge clk) begin
    if (rst) begin
      dest_q       <= 4'd0;
      result_q     <= '0;
      we_q         <= 1'b0;
      wb_count_q   <= '0;
      drop_count_q <= '0;
    end else if (flush) begin
      // Bubble; counters are deliberately left alone.
      dest_q   <= 4'd0;
      result_q <= '0;
      we_q     <= 1'b0;
    end else if (!freeze) begin
      dest_q       <= dest_in;
      result_q     <= result_d;
      we_q         <= we_d;
      wb_count_q   <= wb_count_d;
      drop_count_q <= drop_count_d;
    end
  end

`ifdef WB_PC_WRITE_EN
  // pc_load follows the same rst/flush/freeze rules as the write enable.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      pc_q <= 1'b0;
    end else if (!freeze) begin
      pc_q <= pc_d;
    end
  end

  assign pc_load = pc_q;
`else
  assign pc_load = 1'b0;
`endif

  assign Dest_wb     = dest_q;
  assign Result_WB   = result_q;
  assign writeBackEn = we_q;
  assign wb_count    = wb_count_q;
  assign drop_count  = drop_count_q;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage. Expected outputs are computed from a
// behavioural model when stimulus is driven, queued, and compared one cycle later.
// Counters use CNT_W=8 so wrap-around is reachable in a few hundred cycles.
module tb_wb_stage;

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 8;

  logic          clk;
  logic          rst, freeze, flush, mem_valid, wb_en_in, mem_r_en_in;
  logic [DW-1:0] alu_result, mem_result;
  logic [3:0]    dest_in;
  logic [3:0]    Dest_wb;
  logic [DW-1:0] Result_WB;
  logic          writeBackEn, pc_load;
  logic [CW-1:0] wb_count, drop_count;

  wb_stage #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .freeze     (freeze),
    .flush      (flush),
    .mem_valid  (mem_valid),
    .wb_en_in   (wb_en_in),
    .mem_r_en_in(mem_r_en_in),
    .alu_result (alu_result),
    .mem_result (mem_result),
    .dest_in    (dest_in),
    .Dest_wb    (Dest_wb),
    .Result_WB  (Result_WB),
    .writeBackEn(writeBackEn),
    .pc_load    (pc_load),
    .wb_count   (wb_count),
    .drop_count (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model: commits on the falling edge.
  logic [DW-1:0] rf [16];
  always @(negedge clk) if (writeBackEn) rf[Dest_wb] <= Result_WB;

  typedef struct packed {
    logic [3:0]    dest;
    logic [DW-1:0] res;
    logic          we;
    logic          pc;
    logic [CW-1:0] wbc;
    logic [CW-1:0] drop;
  } exp_t;

  exp_t m;        // model state
  exp_t e;        // popped expectation
  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  function automatic exp_t observed();
    exp_t o;
    o.dest = Dest_wb; o.res = Result_WB; o.we = writeBackEn;
    o.pc = pc_load; o.wbc = wb_count; o.drop = drop_count;
    return o;
  endfunction

  // Drive one cycle, advance the model, queue the expectation, sample after posedge.
  task automatic apply(input logic r, input logic fz, input logic fl, input logic v,
                       input logic en, input logic rd, input logic [DW-1:0] alu,
                       input logic [DW-1:0] mem, input logic [3:0] d);
    logic wr;
    rst = r; freeze = fz; flush = fl; mem_valid = v; wb_en_in = en;
    mem_r_en_in = rd; alu_result = alu; mem_result = mem; dest_in = d;
    wr = v & en;
    if (r) begin
      m = '0;
    end else if (fl) begin
      m.dest = 4'd0; m.res = '0; m.we = 1'b0; m.pc = 1'b0;
    end else if (!fz) begin
      m.dest = d;
      m.res  = rd ? mem : alu;
      if (d != 4'd15) begin
        m.we = wr; m.pc = 1'b0;
      end else begin
`ifdef WB_PC_WRITE_EN
        m.we = wr; m.pc = wr;
`else
        m.we = 1'b0; m.pc = 1'b0;
        if (wr) m.drop = m.drop + 1'b1;
`endif
      end
      if (m.we) m.wbc = m.wbc + 1'b1;
    end
    sb.push_back(m);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      apply(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            $urandom, $urandom, 4'($urandom));
      e = sb.pop_front(); total++;
      if (observed() !== e || e !== '0) begin
        bad++; $display("FAIL reset got=%h want=%h", observed(), exp_t'('0));
      end
    end
    apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'hAA, 32'h0, 4'd3);
    e = sb.pop_front(); total++;
    if (observed() !== e || Dest_wb !== 4'd3 || Result_WB !== 32'hAA || writeBackEn !== 1'b1
        || wb_count !== 8'd1) begin
      bad++; $display("FAIL first_write got=%h want=%h", observed(), e);
    end
  endtask

  task automatic test_load_select();
    apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h1234, 32'hDEADBEEF, 4'd7);
    e = sb.pop_front(); total++;
    if (observed() !== e || Result_WB !== 32'hDEADBEEF || Dest_wb !== 4'd7) begin
      bad++; $display("FAIL load_select got=%h want=%h", observed(), e);
    end
    @(negedge clk); #1;
    total++;
    if (rf[7] !== 32'hDEADBEEF) begin
      bad++; $display("FAIL rf_r7 got=%h want=%h", rf[7], 32'hDEADBEEF);
    end
  endtask

  task automatic test_freeze();
    logic [CW-1:0] cnt;
    apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h55, 32'h0, 4'd5);
    e = sb.pop_front(); total++;
    if (observed() !== e) begin
      bad++; $display("FAIL freeze_capture got=%h want=%h", observed(), e);
    end
    cnt = wb_count;
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h66, 32'h0, 4'd6);
      e = sb.pop_front(); total++;
      if (observed() !== e || Dest_wb !== 4'd5 || Result_WB !== 32'h55 || wb_count !== cnt) begin
        bad++; $display("FAIL freeze_hold got=%h want=%h", observed(), e);
      end
    end
    apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h66, 32'h0, 4'd6);
    e = sb.pop_front(); total++;
    if (observed() !== e || Dest_wb !== 4'd6 || Result_WB !== 32'h66) begin
      bad++; $display("FAIL freeze_release got=%h want=%h", observed(), e);
    end
  endtask

  task automatic test_flush_freeze();
    apply(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h22, 32'h0, 4'd2);
    e = sb.pop_front(); total++;
    if (observed() !== e || writeBackEn !== 1'b0) begin
      bad++; $display("FAIL flush_in_freeze got=%h want=%h", observed(), e);
    end
    apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h23, 32'h0, 4'd2);
    e = sb.pop_front(); total++;
    if (observed() !== e || writeBackEn !== 1'b1 || Result_WB !== 32'h23) begin
      bad++; $display("FAIL after_flush got=%h want=%h", observed(), e);
    end
  endtask

  task automatic test_r15();
    apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 4'd15);
    e = sb.pop_front(); total++;
`ifdef WB_PC_WRITE_EN
    if (observed() !== e || writeBackEn !== 1'b1 || pc_load !== 1'b1 || Result_WB !== 32'h100
        || drop_count !== 8'd0) begin
      bad++; $display("FAIL r15_write got=%h want=%h", observed(), e);
    end
`else
    if (observed() !== e || writeBackEn !== 1'b0 || pc_load !== 1'b0 || drop_count !== 8'd1) begin
      bad++; $display("FAIL r15_drop got=%h want=%h", observed(), e);
    end
`endif
  endtask

  task automatic test_back_to_back();
    apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'hA1, 32'h0, 4'd9);
    e = sb.pop_front(); total++;
    if (observed() !== e) begin
      bad++; $display("FAIL b2b_first got=%h want=%h", observed(), e);
    end
    @(negedge clk); #1;
    total++;
    if (rf[9] !== 32'hA1) begin
      bad++; $display("FAIL b2b_rf_first got=%h want=%h", rf[9], 32'hA1);
    end
    apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'hA2, 32'h0, 4'd9);
    e = sb.pop_front(); total++;
    if (observed() !== e) begin
      bad++; $display("FAIL b2b_second got=%h want=%h", observed(), e);
    end
    @(negedge clk); #1;
    total++;
    if (rf[9] !== 32'hA2) begin
      bad++; $display("FAIL b2b_rf_second got=%h want=%h", rf[9], 32'hA2);
    end
  endtask

  task automatic test_counter_wrap();
    int guard = 0;
    while (m.wbc != 8'hFF && guard < 300) begin
      apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'(guard), 32'h0, 4'd1);
      e = sb.pop_front(); total++;
      if (observed() !== e) begin
        bad++; $display("FAIL wrap_fill got=%h want=%h", observed(), e);
      end
      guard++;
    end
    apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'hBEEF, 32'h0, 4'd4);
    e = sb.pop_front(); total++;
    if (observed() !== e || wb_count !== 8'd0) begin
      bad++; $display("FAIL wrap got=%h want=%h", observed(), e);
    end
    apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'hCAFE, 32'h0, 4'd4);
    e = sb.pop_front(); total++;
    if (observed() !== e || writeBackEn !== 1'b0 || wb_count !== 8'd0) begin
      bad++; $display("FAIL invalid_no_count got=%h want=%h", observed(), e);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      apply(1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 5) == 0), 1'($urandom), 1'($urandom), 1'($urandom),
            $urandom, $urandom, 4'($urandom));
      e = sb.pop_front(); total++;
      if (observed() !== e) begin
        bad++; $display("FAIL random[%0d] got=%h want=%h", i, observed(), e);
      end
    end
    // Reset while stalled and flushing clears everything.
    apply(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h77, 32'h0, 4'd8);
    e = sb.pop_front(); total++;
    if (observed() !== e || e !== '0) begin
      bad++; $display("FAIL reset_mid_stall got=%h want=%h", observed(), exp_t'('0));
    end
  endtask

  initial begin
    m = '0;
    for (int i = 0; i < 16; i++) rf[i] = '0;
    test_reset();
    test_load_select();
    test_freeze();
    test_flush_freeze();
    test_r15();
    test_back_to_back();
    test_counter_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
